// File: rtl/mem_access_unit.sv
// Purpose : MEM-stage data-port controller. Turns an EX load/store into a word-aligned memory
//           request with byte enables and lane-shifted store data, then holds the completed
//           access (raw read word, mbe, write data, address, latency) for MEM/WB.
// Latency : accept cycle -> request from the next cycle until data_resp -> DONE; 3 cycles minimum
//           with a 1-cycle memory.
// Backpressure: stall_out freezes the pipeline during accept and BUSY; DONE waits for advance.
// Ports   : clk/rst (sync, active-high); valid_in/is_load/is_store/funct3/addr_in/rs2_in from EX;
//           advance from the MEM/WB register; data_* memory port; stall_out to the front end;
//           r_data_out/mbe_out/w_data_out/addr_out/lat_cycles/misalign_err hold the last access.
// Option  : define MEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of issuing
//           them (misalign_err reported in DONE, nothing sent to memory).
module mem_access_unit #(
    parameter int LAT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic             is_load,
    input  logic             is_store,
    input  logic [2:0]       funct3,
    input  logic [31:0]      addr_in,
    input  logic [31:0]      rs2_in,
    input  logic             advance,
    output logic             data_read,
    output logic             data_write,
    output logic [31:0]      data_addr,
    output logic [3:0]       data_mbe,
    output logic [31:0]      data_wdata,
    input  logic             data_resp,
    input  logic [31:0]      data_rdata,
    output logic             stall_out,
    output logic [31:0]      r_data_out,
    output logic [3:0]       mbe_out,
    output logic [31:0]      w_data_out,
    output logic [31:0]      addr_out,
    output logic [LAT_W-1:0] lat_cycles,
    output logic             misalign_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic             w_accept;
    logic             w_misalign;
    logic [1:0]       w_off;
    logic [3:0]       w_mbe;
    logic [31:0]      w_wdata;
    logic [LAT_W-1:0] w_lat_next;
    logic             w_unused_f3;

    logic             r_req_load;
    logic [31:0]      r_req_addr;
    logic [31:0]      r_req_addr_raw;
    logic [3:0]       r_req_mbe;
    logic [31:0]      r_req_wdata;
    logic [LAT_W-1:0] r_lat_cnt;

    // Sign (funct3[2]) only matters for write-back extraction, not for lane selection.
    assign w_unused_f3 = funct3[2];

    assign w_accept = valid_in & (is_load | is_store);
    assign w_off    = addr_in[1:0];

    // Lane steering; funct3[1:0]==11 is not a legal width and is treated as a word.
    always_comb begin
        w_mbe   = 4'b1111;
        w_wdata = rs2_in;
        case (funct3[1:0])
            2'b00: begin
                w_mbe   = 4'b0001 << w_off;
                w_wdata = rs2_in << {w_off, 3'b000};
            end
            2'b01: begin
                // 4-bit shift drops the upper lane, so off=3 gives 4'b1000.
                w_mbe   = 4'b0011 << w_off;
                w_wdata = rs2_in << {w_off, 3'b000};
            end
            default: begin
                w_mbe   = 4'b1111;
                w_wdata = rs2_in;
            end
        endcase
    end

`ifdef MEM_MISALIGN_TRAP_EN
    logic r_misalign;

    assign w_misalign = ((funct3[1:0] == 2'b01) & (w_off == 2'b11)) |
                        (funct3[1] & (w_off != 2'b00));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_misalign <= 1'b0;
        end else if ((r_state == S_IDLE) && w_accept) begin
            r_misalign <= w_misalign;
        end
    end

    assign misalign_err = r_misalign & (r_state == S_DONE);
`else
    assign w_misalign   = 1'b0;
    assign misalign_err = 1'b0;
`endif

    // Counts the resp cycle too, so a 1-cycle memory reports 1.
    assign w_lat_next = (&r_lat_cnt) ? r_lat_cnt : r_lat_cnt + 1'b1;

    always_comb begin
        w_next    = r_state;
        stall_out = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    stall_out = 1'b1;
                    w_next    = w_misalign ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                stall_out = 1'b1;
                if (data_resp) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (advance) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Request capture and latency counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_load     <= 1'b0;
            r_req_addr     <= '0;
            r_req_addr_raw <= '0;
            r_req_mbe      <= '0;
            r_req_wdata    <= '0;
            r_lat_cnt      <= '0;
        end else if ((r_state == S_IDLE) && w_accept) begin
            r_req_load     <= is_load;
            r_req_addr     <= {addr_in[31:2], 2'b00};
            r_req_addr_raw <= addr_in;
            r_req_mbe      <= w_mbe;
            r_req_wdata    <= w_wdata;
            r_lat_cnt      <= '0;
        end else if (r_state == S_BUSY) begin
            r_lat_cnt      <= w_lat_next;
        end
    end

    // Completed-access results, held until the next access completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_out <= '0;
            mbe_out    <= '0;
            w_data_out <= '0;
            addr_out   <= '0;
            lat_cycles <= '0;
        end else if ((r_state == S_BUSY) && data_resp) begin
            r_data_out <= r_req_load ? data_rdata : 32'h0;
            mbe_out    <= r_req_mbe;
            w_data_out <= r_req_wdata;
            addr_out   <= r_req_addr_raw;
            lat_cycles <= w_lat_next;
        end else if ((r_state == S_IDLE) && w_accept && w_misalign) begin
            // Trapped access never reached memory: no lanes, no data, no latency.
            r_data_out <= '0;
            mbe_out    <= '0;
            w_data_out <= w_wdata;
            addr_out   <= addr_in;
            lat_cycles <= '0;
        end
    end

    assign data_read  = (r_state == S_BUSY) &  r_req_load;
    assign data_write = (r_state == S_BUSY) & ~r_req_load;
    assign data_addr  = r_req_addr;
    assign data_mbe   = r_req_mbe;
    assign data_wdata = r_req_wdata;

endmodule
